sphere_hit_scan: RTL and testbench

SPHERE_HIT_SCAN -- requirements
Module: sphere_hit_scan

---
 rtl/sphere_hit_scan.sv | 158 +++++++++++++++
 tb/tb_sphere_hit_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sphere_hit_scan.sv
// +--------------------------------------------------------------------------+
// | sphere_hit_scan: nearest ray/sphere hit over four spheres, 7-cycle scan  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sphere_hit_scan #(
  parameter logic [63:0] RADIUS_SQ = 64'd57600 << 32,
  parameter logic [23:0] BG_COL    = 24'h000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0][63:0] Ray_dir,
  output logic [1:0]       Read_index,
  input  logic [2:0][63:0] Sphere_pos,
  input  logic [1:0]       curr_index,
  input  logic [3:0][23:0] Sphere_col,
  output logic             Busy,
  output logic             Done,
  output logic [23:0]      Pixel_col,
  output logic             Hit,
  output logic [1:0]       Hit_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [2:0][63:0] dir;
  logic [1:0]       issue_cnt;
  logic             in_valid, in_last;
  logic             s1_valid, s1_last;
  logic [1:0]       s1_tag;
  logic [63:0]      s1_t, s1_c2;
  logic             best_hit;
  logic [1:0]       best_idx;
  logic [63:0]      best_t;
  logic [23:0]      held_col;
  logic [1:0]       held_idx;

  logic [63:0]      t_new, c2_new, d2;
  logic             s1_hit, take;
  logic             accept;

  // 32.32 multiply: full signed 128-bit product, keep bits [95:32].
  function automatic logic [63:0] mulq(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    return 64'(p >> 32);
  endfunction

  assign accept = (state == IDLE) && Start;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    Read_index = 2'd0;
    Busy       = (state != IDLE);
    Done       = (state == DONE);
    case (state)
      IDLE:  if (Start) state_nx = ISSUE;
      ISSUE: begin
        Read_index = issue_cnt;
        if (issue_cnt == 2'd3) state_nx = DRAIN;
      end
      DRAIN: if (s1_valid && s1_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage 1 operands: the latched direction against the sphere word just returned.
  assign t_new  = mulq(dir[0], Sphere_pos[0]) + mulq(dir[1], Sphere_pos[1])
                + mulq(dir[2], Sphere_pos[2]);
  assign c2_new = mulq(Sphere_pos[0], Sphere_pos[0]) + mulq(Sphere_pos[1], Sphere_pos[1])
                + mulq(Sphere_pos[2], Sphere_pos[2]);

  // Stage 2 resolves the hit and folds it straight into the running best.
  assign d2     = s1_c2 - mulq(s1_t, s1_t);
  assign s1_hit = ($signed(s1_t) > 64'sd0) && ($signed(d2) < $signed(RADIUS_SQ));
  assign take   = s1_valid && s1_hit &&
                  (!best_hit || ($signed(s1_t) < $signed(best_t)) ||
                   ((s1_t == best_t) && (s1_tag < best_idx)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir       <= '0;
      issue_cnt <= 2'd0;
      in_valid  <= 1'b0;
      in_last   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_tag    <= 2'd0;
      s1_t      <= 64'd0;
      s1_c2     <= 64'd0;
      best_hit  <= 1'b0;
      best_idx  <= 2'd0;
      best_t    <= 64'd0;
      held_col  <= BG_COL;
      held_idx  <= 2'd0;
    end else begin
      if (accept) begin
        dir       <= Ray_dir;
        issue_cnt <= 2'd0;
      end else if (state == ISSUE) begin
        issue_cnt <= issue_cnt + 2'd1;
      end

      in_valid <= (state == ISSUE);
      in_last  <= (state == ISSUE) && (issue_cnt == 2'd3);
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_tag   <= curr_index;
      s1_t     <= t_new;
      s1_c2    <= c2_new;

      if (accept) begin
        best_hit <= 1'b0;
        best_idx <= 2'd0;
        best_t   <= 64'd0;
      end else if (take) begin
        best_hit <= 1'b1;
        best_idx <= s1_tag;
        best_t   <= s1_t;
      end

      if (state == DONE) begin
        held_col <= Pixel_col;
        held_idx <= Hit_index;
      end
    end
  end

  // Result is live during DONE (colour sampled that cycle) and held afterwards.
  always_comb begin
    Pixel_col = held_col;
    Hit_index = held_idx;
    Hit       = 1'b0;
    if (state == DONE) begin
      Hit       = best_hit;
      Pixel_col = best_hit ? Sphere_col[best_idx] : BG_COL;
      Hit_index = best_hit ? best_idx : 2'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sphere_hit_scan.sv
// +--------------------------------------------------------------------------+
// | tb_sphere_hit_scan: directed self-checking bench for sphere_hit_scan     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sphere_hit_scan;

  localparam logic [23:0] BG   = 24'h0A0B0C;
  localparam logic [63:0] ONE  = 64'h1_0000_0000;
  localparam logic [63:0] Y48  = 64'd4800 << 32;
  localparam logic [63:0] Y96  = 64'd9600 << 32;
  localparam logic [63:0] NY48 = -(64'd4800 << 32);
  localparam logic [63:0] X239 = 64'd239 << 32;
  localparam logic [63:0] X241 = 64'd241 << 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0][63:0] ray_dir;
  logic [1:0]       read_index;
  logic [2:0][63:0] sphere_pos;
  logic [1:0]       curr_index;
  logic [3:0][23:0] sphere_col;
  logic             busy, done, hit;
  logic [23:0]      pixel_col;
  logic [1:0]       hit_index;

  logic [2:0][63:0] pos_mem [4];

  int errors = 0;
  int checks = 0;

  sphere_hit_scan #(.BG_COL(BG)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Ray_dir(ray_dir),
    .Read_index(read_index), .Sphere_pos(sphere_pos), .curr_index(curr_index),
    .Sphere_col(sphere_col), .Busy(busy), .Done(done), .Pixel_col(pixel_col),
    .Hit(hit), .Hit_index(hit_index)
  );

  always #5 clk = ~clk;

  // Sphere register: one-cycle read latency with index tag.
  always @(posedge clk) begin
    sphere_pos <= pos_mem[read_index];
    curr_index <= read_index;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_scene(input logic [63:0] x0, input logic [63:0] y0, input logic [63:0] y1,
                           input logic [63:0] y2, input logic [63:0] y3);
    pos_mem[0] = {64'd0, y0, x0};
    pos_mem[1] = {64'd0, y1, 64'd0};
    pos_mem[2] = {64'd0, y2, 64'd0};
    pos_mem[3] = {64'd0, y3, 64'd0};
  endtask

  task automatic run_scan(input string nm, input logic exp_hit, input logic [1:0] exp_idx,
                          input logic [23:0] exp_col);
    int n;
    @(negedge clk);
    start   = 1'b1;
    ray_dir = {64'd0, ONE, 64'd0};
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({nm, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < 20) begin
      if (n <= 4) check({nm, "_read_index"}, 64'(read_index), 64'(n - 1));
      @(negedge clk);
      n++;
    end
    check({nm, "_done_cycle"}, 64'(n), 64'd7);
    check({nm, "_hit"}, 64'(hit), 64'(exp_hit));
    check({nm, "_hit_index"}, 64'(hit_index), 64'(exp_idx));
    check({nm, "_pixel_col"}, 64'(pixel_col), 64'(exp_col));
    @(negedge clk);
    check({nm, "_done_after"}, 64'(done), 64'd0);
    check({nm, "_busy_after"}, 64'(busy), 64'd0);
    check({nm, "_hit_after"}, 64'(hit), 64'd0);
    check({nm, "_col_held"}, 64'(pixel_col), 64'(exp_col));
    check({nm, "_idx_held"}, 64'(hit_index), 64'(exp_idx));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    rst        = 1'b1;
    start      = 1'b0;
    ray_dir    = '0;
    sphere_col = {24'h44DD44, 24'h33CC33, 24'h22BB22, 24'h11AA11};
    set_scene(64'd0, Y48, NY48, NY48, NY48);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_hit_index", 64'(hit_index), 64'd0);
    check("rst_read_index", 64'(read_index), 64'd0);
    check("rst_pixel_col", 64'(pixel_col), 64'(BG));
    rst = 1'b0;

    set_scene(64'd0, Y48, NY48, NY48, NY48);
    run_scan("s0_front", 1'b1, 2'd0, 24'h11AA11);

    set_scene(64'd0, Y96, NY48, Y48, NY48);
    run_scan("nearest_s2", 1'b1, 2'd2, 24'h33CC33);

    set_scene(64'd0, NY48, Y48, NY48, Y48);
    run_scan("tie_s1_s3", 1'b1, 2'd1, 24'h22BB22);

    set_scene(X239, Y48, NY48, NY48, NY48);
    run_scan("edge_239", 1'b1, 2'd0, 24'h11AA11);

    set_scene(X241, Y48, NY48, NY48, NY48);
    run_scan("edge_241", 1'b0, 2'd0, BG);

    // Start re-pulsed in cycles 3 and 7 must be ignored.
    set_scene(64'd0, Y48, NY48, NY48, NY48);
    @(negedge clk);
    start   = 1'b1;
    ray_dir = {64'd0, ONE, 64'd0};
    dones   = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 7);
      if (done) dones++;
      if (c == 7) check("restart_done_c7", 64'(done), 64'd1);
      if (c == 8) check("restart_busy_c8", 64'(busy), 64'd0);
    end
    start = 1'b0;
    check("restart_single_done", 64'(dones), 64'd1);

    // Reset in cycle 4 aborts the scan.
    @(negedge clk);
    start = 1'b1;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = (c == 4);
      if (done) dones++;
      if (c == 5) begin
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_pixel_col", 64'(pixel_col), 64'(BG));
        check("abort_hit_index", 64'(hit_index), 64'd0);
        check("abort_hit", 64'(hit), 64'd0);
      end
    end
    check("abort_no_done", 64'(dones), 64'd0);

    set_scene(64'd0, Y96, NY48, Y48, NY48);
    run_scan("after_abort", 1'b1, 2'd2, 24'h33CC33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
